// File: rtl/module_status_monitor.sv
// module_status_monitor: watches NUM_CH ap_ctrl-style handshakes and keeps
// per-channel statistics in hardware. Each channel tracks:
//   - completed transactions
//   - last, minimum and maximum latency
//   - cycles spent stalled on ap_continue
//   - cycles with ap_ready high
// Statistics are read through a one-cycle-latency register port. A finish
// pulse freezes everything so that end-of-run values stay stable for dumping.
// Every counter saturates at all-ones instead of wrapping.

module module_status_monitor #(
  parameter int NUM_CH = 10,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              finish,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic              frozen,
  output logic [NUM_CH-1:0] busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Read field of every channel for the current rd_sel, flattened so each
  // channel's generate block drives only its own slice.
  logic [NUM_CH*CNT_W-1:0] field_flat;
  logic [CNT_W-1:0]        sel_data;
  logic                    rd_bad;

  // Saturating increment: stick at all-ones rather than wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] txn_count;
    logic [CNT_W-1:0] last_lat;
    logic [CNT_W-1:0] min_lat;
    logic [CNT_W-1:0] max_lat;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] ready_count;
    logic             complete;
    logic [CNT_W-1:0] latency;
    logic [CNT_W-1:0] field;

    // Detect a completing transaction this cycle and the latency it reports.
    // A start with a same-cycle done counts as latency 1; a RUN completion
    // reports the running count plus the done cycle itself.
    always_comb begin
      complete = 1'b0;
      latency  = CNT_ONE;
      if (ch_en[i]) begin
        case (state)
          IDLE: begin
            complete = ap_start[i] & ap_done[i];
            latency  = CNT_ONE;
          end
          RUN: begin
            complete = ap_done[i];
            latency  = sat_inc(lat_cnt);
          end
          default: begin
            complete = 1'b0;
            latency  = CNT_ONE;
          end
        endcase
      end
    end

    // Channel handshake FSM and its statistics. Clear wins over everything;
    // while frozen the channel holds; a disabled channel drops to IDLE
    // without touching its counters.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state        <= IDLE;
        lat_cnt      <= '0;
        txn_count    <= '0;
        last_lat     <= '0;
        min_lat      <= '1;
        max_lat      <= '0;
        stall_cycles <= '0;
        ready_count  <= '0;
      end else if (clear) begin
        state        <= IDLE;
        lat_cnt      <= '0;
        txn_count    <= '0;
        last_lat     <= '0;
        min_lat      <= '1;
        max_lat      <= '0;
        stall_cycles <= '0;
        ready_count  <= '0;
      end else if (!frozen) begin
        if (!ch_en[i]) begin
          state <= IDLE;
        end else begin
          if (ap_ready[i]) begin
            ready_count <= sat_inc(ready_count);
          end
          if (complete) begin
            txn_count <= sat_inc(txn_count);
            last_lat  <= latency;
            if (latency < min_lat) begin
              min_lat <= latency;
            end
            if (latency > max_lat) begin
              max_lat <= latency;
            end
          end
          case (state)
            IDLE: begin
              if (ap_start[i]) begin
                if (ap_done[i]) begin
                  state <= ap_continue[i] ? IDLE : HOLD;
                end else begin
                  state   <= RUN;
                  lat_cnt <= CNT_ONE;
                end
              end
            end
            RUN: begin
              if (ap_done[i]) begin
                state <= ap_continue[i] ? IDLE : HOLD;
              end else begin
                lat_cnt <= sat_inc(lat_cnt);
              end
            end
            HOLD: begin
              if (!ap_continue[i]) begin
                stall_cycles <= sat_inc(stall_cycles);
              end else if (ap_start[i]) begin
                state   <= RUN;
                lat_cnt <= CNT_ONE;
              end else begin
                state <= IDLE;
              end
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end

    // Select this channel's field for the readout; min_lat is hidden until
    // at least one transaction has completed so an empty channel reads 0.
    always_comb begin
      field = '0;
      case (rd_sel)
        3'd0:    field = txn_count;
        3'd1:    field = last_lat;
        3'd2:    field = (txn_count == '0) ? '0 : min_lat;
        3'd3:    field = max_lat;
        3'd4:    field = stall_cycles;
        3'd5:    field = ready_count;
        3'd6:    field = {{(CNT_W-2){1'b0}}, state};
        default: field = '0;
      endcase
    end

    assign field_flat[i*CNT_W +: CNT_W] = field;
    assign busy[i] = (state != IDLE);
  end

  // Channel select for the readout; out-of-range channels and field 7 are
  // flagged as errors and return zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        sel_data = field_flat[i*CNT_W +: CNT_W];
      end
    end
    rd_bad = ({1'b0, rd_ch} >= (CH_W+1)'(NUM_CH)) || (rd_sel == 3'd7);
  end

  // Freeze flag: set by finish, cleared only by clear (which has priority).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frozen <= 1'b0;
    end else if (clear) begin
      frozen <= 1'b0;
    end else if (finish) begin
      frozen <= 1'b1;
    end
  end

  // Registered read response: one cycle after the request, returning the
  // statistics as they stood before that cycle's update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req && !rd_bad) begin
        rd_data <= sel_data;
        rd_err  <= 1'b0;
      end else if (rd_req) begin
        rd_data <= '0;
        rd_err  <= 1'b1;
      end else begin
        rd_data <= '0;
        rd_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_module_status_monitor.sv
// tb_module_status_monitor: drives two monitors (10 channels x 32-bit and
// 4 channels x 4-bit, sharing the low stimulus bits) with directed scenarios
// and random traffic. Expected values come from a transaction-level model
// that measures latency as elapsed live cycles between start and done.

module tb_module_status_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  ch_en, ap_start, ap_ready, ap_done, ap_continue;
  logic        finish, clear, rd_req;
  logic [3:0]  rd_ch;
  logic [2:0]  rd_sel;

  logic        rd_valid0, rd_err0, frozen0;
  logic [31:0] rd_data0;
  logic [9:0]  busy0;
  logic        rd_valid1, rd_err1, frozen1;
  logic [3:0]  rd_data1;
  logic [3:0]  busy1;

  always #5 clock = ~clock;

  module_status_monitor #(.NUM_CH(10), .CNT_W(32)) dut_big (
    .clock(clock), .reset(reset), .ch_en(ch_en), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .finish(finish), .clear(clear), .rd_req(rd_req), .rd_ch(rd_ch),
    .rd_sel(rd_sel), .rd_valid(rd_valid0), .rd_data(rd_data0),
    .rd_err(rd_err0), .frozen(frozen0), .busy(busy0)
  );

  module_status_monitor #(.NUM_CH(4), .CNT_W(4)) dut_small (
    .clock(clock), .reset(reset), .ch_en(ch_en[3:0]), .ap_start(ap_start[3:0]),
    .ap_ready(ap_ready[3:0]), .ap_done(ap_done[3:0]), .ap_continue(ap_continue[3:0]),
    .finish(finish), .clear(clear), .rd_req(rd_req), .rd_ch(rd_ch[1:0]),
    .rd_sel(rd_sel), .rd_valid(rd_valid1), .rd_data(rd_data1),
    .rd_err(rd_err1), .frozen(frozen1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = 10ch/32-bit monitor, 1 = 4ch/4-bit monitor.
  int     nch [2] = '{10, 4};
  longint cmax[2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
  longint m_txn[2][10], m_last[2][10], m_min[2][10], m_max[2][10];
  longint m_stall[2][10], m_ready[2][10], m_start[2][10];
  int     m_phase[2][10];   // 0 idle, 1 in flight, 2 waiting for continue
  longint m_live[2];        // cycles in which statistics were live
  bit     m_frozen[2];
  bit     e_valid[2], e_err[2];
  longint e_data[2];

  logic [63:0] obs_data[2];
  logic        obs_err[2], obs_valid[2], obs_frozen[2];
  logic [9:0]  obs_busy[2];

  function automatic longint satAdd(longint v, longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic clearStats(int d);
    for (int c = 0; c < 10; c++) begin
      m_txn[d][c] = 0; m_last[d][c] = 0; m_min[d][c] = cmax[d]; m_max[d][c] = 0;
      m_stall[d][c] = 0; m_ready[d][c] = 0; m_start[d][c] = 0; m_phase[d][c] = 0;
    end
    m_live[d] = 0;
    m_frozen[d] = 1'b0;
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      clearStats(d);
      e_valid[d] = 1'b0; e_err[d] = 1'b0; e_data[d] = 0;
    end
  endtask

  task automatic finishTxn(int d, int c, longint lat);
    m_txn[d][c]  = satAdd(m_txn[d][c], cmax[d]);
    m_last[d][c] = lat;
    if (lat < m_min[d][c]) m_min[d][c] = lat;
    if (lat > m_max[d][c]) m_max[d][c] = lat;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic modelStep();
    int ch;
    longint lat;
    for (int d = 0; d < 2; d++) begin
      ch = (d == 0) ? int'(rd_ch) : int'(rd_ch[1:0]);
      e_valid[d] = rd_req; e_err[d] = 1'b0; e_data[d] = 0;
      if (rd_req) begin
        if (ch >= nch[d] || rd_sel == 3'd7) e_err[d] = 1'b1;
        else begin
          case (rd_sel)
            3'd0: e_data[d] = m_txn[d][ch];
            3'd1: e_data[d] = m_last[d][ch];
            3'd2: e_data[d] = (m_txn[d][ch] == 0) ? 0 : m_min[d][ch];
            3'd3: e_data[d] = m_max[d][ch];
            3'd4: e_data[d] = m_stall[d][ch];
            3'd5: e_data[d] = m_ready[d][ch];
            default: e_data[d] = m_phase[d][ch];
          endcase
        end
      end
      if (clear) clearStats(d);
      else if (!m_frozen[d]) begin
        for (int c = 0; c < nch[d]; c++) begin
          if (!ch_en[c]) m_phase[d][c] = 0;
          else begin
            if (ap_ready[c]) m_ready[d][c] = satAdd(m_ready[d][c], cmax[d]);
            if (m_phase[d][c] == 0) begin
              if (ap_start[c] && ap_done[c]) begin
                finishTxn(d, c, 1);
                m_phase[d][c] = ap_continue[c] ? 0 : 2;
              end else if (ap_start[c]) begin
                m_phase[d][c] = 1; m_start[d][c] = m_live[d];
              end
            end else if (m_phase[d][c] == 1) begin
              if (ap_done[c]) begin
                lat = m_live[d] - m_start[d][c] + 1;
                if (lat > cmax[d]) lat = cmax[d];
                finishTxn(d, c, lat);
                m_phase[d][c] = ap_continue[c] ? 0 : 2;
              end
            end else begin
              if (!ap_continue[c]) m_stall[d][c] = satAdd(m_stall[d][c], cmax[d]);
              else if (ap_start[c]) begin
                m_phase[d][c] = 1; m_start[d][c] = m_live[d];
              end else m_phase[d][c] = 0;
            end
          end
        end
        m_live[d] = m_live[d] + 1;
        m_frozen[d] = finish;
      end
    end
  endtask

  task automatic checkVal(string tag, int d, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [9:0] eb;
    obs_valid[0] = rd_valid0; obs_data[0] = 64'(rd_data0); obs_err[0] = rd_err0;
    obs_frozen[0] = frozen0;  obs_busy[0] = busy0;
    obs_valid[1] = rd_valid1; obs_data[1] = 64'(rd_data1); obs_err[1] = rd_err1;
    obs_frozen[1] = frozen1;  obs_busy[1] = {6'b0, busy1};
    for (int d = 0; d < 2; d++) begin
      eb = '0;
      for (int c = 0; c < nch[d]; c++) eb[c] = (m_phase[d][c] != 0);
      checkVal("rd_valid", d, 64'(obs_valid[d]), 64'(e_valid[d]));
      checkVal("rd_data", d, obs_data[d], e_data[d]);
      checkVal("rd_err", d, 64'(obs_err[d]), 64'(e_err[d]));
      checkVal("frozen", d, 64'(obs_frozen[d]), 64'(m_frozen[d]));
      checkVal("busy", d, 64'(obs_busy[d]), 64'(eb));
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic applyStimulus();
    modelStep();
    @(posedge clock);
    @(negedge clock);
    checkOutput();
  endtask

  task automatic setIdle();
    ch_en = '1; ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    finish = 1'b0; clear = 1'b0; rd_req = 1'b0; rd_ch = '0; rd_sel = '0;
  endtask

  task automatic readField(int ch, int sel);
    rd_req = 1'b1; rd_ch = 4'(ch); rd_sel = 3'(sel);
    applyStimulus();
    rd_req = 1'b0;
  endtask

  task automatic runIdle(int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  initial begin
    setIdle();
    modelReset();
    repeat (3) @(negedge clock);
    checkOutput();
    reset = 1'b1;
    $display("[TB] reset released");

    // Scenario 1: ch0 latency-5 transaction, continue tied high.
    ap_start[0] = 1'b1; applyStimulus(); ap_start[0] = 1'b0;
    checkVal("t1_busy_c1", 0, 64'(busy0[0]), 64'd1);
    runIdle(3);
    ap_done[0] = 1'b1; applyStimulus(); ap_done[0] = 1'b0;
    checkVal("t1_busy_c5", 0, 64'(busy0[0]), 64'd0);
    readField(0, 0); checkVal("t1_txn", 0, obs_data[0], 64'd1);
    readField(0, 1); checkVal("t1_last", 0, obs_data[0], 64'd5);
    readField(0, 2); checkVal("t1_min", 0, obs_data[0], 64'd5);
    readField(0, 3); checkVal("t1_max", 0, obs_data[0], 64'd5);
    readField(0, 4); checkVal("t1_stall", 0, obs_data[0], 64'd0);

    // Scenario 2: ch3 latency 3 followed by a 3-cycle continue stall.
    ap_start[3] = 1'b1; applyStimulus(); ap_start[3] = 1'b0;
    applyStimulus();
    ap_done[3] = 1'b1; ap_continue[3] = 1'b0; applyStimulus(); ap_done[3] = 1'b0;
    readField(3, 6); checkVal("t2_state_hold", 0, obs_data[0], 64'd2);
    runIdle(2);
    ap_continue[3] = 1'b1; applyStimulus();
    readField(3, 6); checkVal("t2_state_idle", 0, obs_data[0], 64'd0);
    readField(3, 4); checkVal("t2_stall", 0, obs_data[0], 64'd3);
    readField(3, 1); checkVal("t2_last", 0, obs_data[0], 64'd3);

    // Scenario 3: ch1 two single-cycle transactions then a 7-cycle one.
    ap_start[1] = 1'b1; ap_done[1] = 1'b1; applyStimulus(); applyStimulus();
    ap_done[1] = 1'b0; applyStimulus(); ap_start[1] = 1'b0;
    runIdle(5);
    ap_done[1] = 1'b1; applyStimulus(); ap_done[1] = 1'b0;
    readField(1, 0); checkVal("t3_txn", 0, obs_data[0], 64'd3);
    readField(1, 2); checkVal("t3_min", 0, obs_data[0], 64'd1);
    readField(1, 3); checkVal("t3_max", 0, obs_data[0], 64'd7);
    readField(1, 1); checkVal("t3_last", 0, obs_data[0], 64'd7);

    // Scenario 4: saturation of the 4-bit monitor on ch2.
    ap_start[2] = 1'b1; ap_done[2] = 1'b1; runIdle(20);
    ap_done[2] = 1'b0; applyStimulus(); ap_start[2] = 1'b0;
    runIdle(14);
    ap_done[2] = 1'b1; applyStimulus(); ap_done[2] = 1'b0;
    readField(2, 0);
    checkVal("t4_txn_sat", 1, obs_data[1], 64'd15);
    checkVal("t4_txn_wide", 0, obs_data[0], 64'd21);
    readField(2, 1);
    checkVal("t4_last_sat", 1, obs_data[1], 64'd15);
    checkVal("t4_last_wide", 0, obs_data[0], 64'd16);

    // Scenario 5: freeze, activity ignored, then clear and clear+finish.
    finish = 1'b1; applyStimulus(); finish = 1'b0;
    checkVal("t5_frozen", 0, 64'(frozen0), 64'd1);
    ap_start[0] = 1'b1; ap_done[0] = 1'b1; ap_ready[0] = 1'b1; runIdle(5);
    ap_start[0] = 1'b0; ap_done[0] = 1'b0; ap_ready[0] = 1'b0;
    readField(0, 0); checkVal("t5_txn_frozen", 0, obs_data[0], 64'd1);
    readField(0, 1); checkVal("t5_last_frozen", 0, obs_data[0], 64'd5);
    clear = 1'b1; applyStimulus(); clear = 1'b0;
    checkVal("t5_unfrozen", 0, 64'(frozen0), 64'd0);
    readField(0, 0); checkVal("t5_txn_clr", 0, obs_data[0], 64'd0);
    readField(0, 2); checkVal("t5_min_clr", 0, obs_data[0], 64'd0);
    clear = 1'b1; finish = 1'b1; applyStimulus(); clear = 1'b0; finish = 1'b0;
    checkVal("t5_clr_over_fin", 0, 64'(frozen0), 64'd0);

    // Scenario 6: reset mid-RUN with a read in flight, then bad channel read.
    ap_start[4] = 1'b1; applyStimulus(); ap_start[4] = 1'b0;
    applyStimulus();
    rd_req = 1'b1; rd_ch = 4'd4; rd_sel = 3'd0;
    modelStep();
    @(posedge clock);
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkVal("t6_rd_valid", 0, 64'(rd_valid0), 64'd0);
    checkVal("t6_busy", 0, 64'(busy0), 64'd0);
    checkOutput();
    rd_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int s = 0; s < 7; s++) readField(4, s);
    readField(4, 2); checkVal("t6_min_zero", 0, obs_data[0], 64'd0);
    readField(10, 0);
    checkVal("t6_bad_err", 0, 64'(obs_err[0]), 64'd1);
    checkVal("t6_bad_data", 0, obs_data[0], 64'd0);

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < 10; c++) begin
        ch_en[c]       = ($urandom_range(0, 99) < 95);
        ap_start[c]    = ($urandom_range(0, 99) < 30);
        ap_done[c]     = ($urandom_range(0, 99) < 30);
        ap_ready[c]    = ($urandom_range(0, 99) < 50);
        ap_continue[c] = ($urandom_range(0, 99) < 70);
      end
      finish = ($urandom_range(0, 99) < 1);
      clear  = ($urandom_range(0, 99) < 2);
      rd_req = ($urandom_range(0, 99) < 70);
      rd_ch  = 4'($urandom_range(0, 11));
      rd_sel = 3'($urandom_range(0, 7));
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_status_monitor.md
Name: module_status_monitor

Overview:
- Parametrised, synthesizable per-module handshake monitor covering NUM_CH ap_ctrl-style modules (ap_start/ap_ready/ap_done/ap_continue).
- Instantiated beside the HLS top in co-simulation, or on-chip in debug builds. It replaces per-channel CSV dumping with in-hardware statistics: transactions, latency (last/min/max), continue-stall cycles and ready count.
- Statistics are read back through a one-cycle-latency register port.
- Counting freezes on finish, so end-of-run values are stable for dump.

Parameters:
- NUM_CH, 10, number of monitored channels (1..64).
- CNT_W, 32, width of every statistic counter (4..64).
- CH_W, max(1,$clog2(NUM_CH)), channel-select width (derived; do not override).

Ports:
- clock, in, 1, single clock; all logic is on the rising edge.
- reset, in, 1, asynchronous assert, active-low; deassertion is synchronous to clock upstream.
- ch_en, in, NUM_CH, per-channel enable. A 0 channel is held in IDLE and never counts; use it for tied-off channels.
- ap_start, in, NUM_CH, per-channel start.
- ap_ready, in, NUM_CH, per-channel ready.
- ap_done, in, NUM_CH, per-channel done.
- ap_continue, in, NUM_CH, per-channel continue. Tie to 1 for non-dataflow modules.
- finish, in, 1, end-of-run. Freezes all statistics.
- clear, in, 1, synchronous clear of all statistics and of the frozen flag.
- rd_req, in, 1, read request.
- rd_ch, in, CH_W, channel to read.
- rd_sel, in, 3, field select.
- rd_valid, out, 1, read data valid.
- rd_data, out, CNT_W, read data.
- rd_err, out, 1, bad channel or field select.
- frozen, out, 1, statistics frozen.
- busy, out, NUM_CH, channel in RUN or HOLD.

Behaviour:
- Reset: all outputs 0; every channel FSM in IDLE; all counters 0; min_lat = all-ones internally.

Per-channel FSM (IDLE=0, RUN=1, HOLD=2):
- IDLE, start without done: go to RUN; lat_cnt=1.
- IDLE, start and done in the same cycle: complete with latency 1. Go to IDLE if continue=1, else HOLD.
- RUN: lat_cnt increments by 1 per cycle, saturating.
- RUN, done: latency = lat_cnt+1. Go to IDLE if continue=1, else HOLD.
- HOLD: stall_cycles increments each cycle continue=0.
- HOLD, continue=1: go to IDLE. If start is also 1 in that cycle, go straight to RUN with lat_cnt=1.
- Completion updates:
  - txn_count += 1
  - last_lat = latency
  - min_lat = min(min_lat, latency)
  - max_lat = max(max_lat, latency)
- ready_count increments on every cycle ap_ready=1 while ch_en=1, independent of state.
- ch_en=0: FSM is forced to IDLE next cycle; counters hold.
- Saturation: every counter and lat_cnt saturates at 2^CNT_W-1 and never wraps.

Freeze and clear:
- finish=1 sets frozen on the next edge.
- While frozen, counters and FSMs hold; inputs are ignored.
- clear has priority over finish and over any counting in the same cycle. It zeroes counters, sets min_lat to all-ones, FSMs to IDLE, and frozen to 0.

Readout:
- rd_req is sampled at an edge; rd_valid=1 and rd_data/rd_err are valid exactly one cycle later.
- Back-to-back requests are allowed, one per cycle.
- rd_valid=0 in cycles with no request response.
- rd_sel mapping:
  - 0 txn_count
  - 1 last_lat
  - 2 min_lat (reads 0 if txn_count=0)
  - 3 max_lat
  - 4 stall_cycles
  - 5 ready_count
  - 6 {zero-extended state[1:0]}
  - 7 invalid
- rd_ch >= NUM_CH or rd_sel=7: rd_data=0, rd_err=1.
- The read returns the value before any update in the sampling cycle.
- busy[i] = (state != IDLE), registered state output.
- Reset asserted mid-operation: immediate return to reset values, including a pending rd_valid.

Test Plan:
1. ch0 start at cycle 0 only, done at cycle 4, continue=1 -> txn=1, last=min=max=5, stall=0, busy[0] high cycles 1-4.
2. ch3 start at 0, done at 2 with continue=0 for 3 cycles then 1 -> latency 3, stall=3, state reads 2 during hold then 0.
3. ch1 start&done same cycle, twice, then a 7-cycle transaction -> txn=3, min=1, max=7, last=7.
4. CNT_W=4: 20 single-cycle transactions on ch2 -> txn=15 (saturated); 16-cycle run -> last_lat=15.
5. Assert finish, then drive 5 transactions on ch0 -> all fields unchanged, frozen=1. clear -> frozen=0, txn=0, min reads 0. clear and finish together -> frozen=0.
6. Reset low mid-RUN on ch4 with a rd_req in flight -> rd_valid=0, busy=0, all fields 0. Read rd_ch=10 (NUM_CH=10) -> rd_err=1, rd_data=0.
